// File: rtl/stream_demux2.sv
// stream_demux2 -- registered 1-to-2 stream demultiplexer.
//
// One n-bit word per cycle is accepted on a valid/ready input and steered by
// in_sel into one of two independent DEPTH-entry FIFOs (0 -> port A,
// 1 -> port B). Each FIFO drives its own valid/ready output port, so the two
// consumers may stall independently. Words are accepted strictly in input
// order: a word aimed at a full FIFO holds off everything behind it.
//
// Optional feature macro: STREAM_DEMUX2_STATS_EN
//   When defined, adds 16-bit wrapping pop counters cnt_a / cnt_b.
//   When undefined, those ports and counters are absent.

module stream_demux2 #(
    parameter int n     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [n-1:0] in_data,
    input  logic         in_sel,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [n-1:0] a_data,
    output logic         a_valid,
    input  logic         a_ready,
    output logic [n-1:0] b_data,
    output logic         b_valid,
    input  logic         b_ready
`ifdef STREAM_DEMUX2_STATS_EN
    ,
    output logic [15:0]  cnt_a,
    output logic [15:0]  cnt_b
`endif
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    // Index 0 is port A, index 1 is port B throughout.
    logic [n-1:0]  mem_r    [2][DEPTH];
    logic [AW-1:0] wr_ptr_r [2];
    logic [AW-1:0] rd_ptr_r [2];
    logic [AW:0]   occ_r    [2];

    logic [1:0]    full_s;
    logic [1:0]    valid_s;
    logic [1:0]    ready_s;
    logic [1:0]    push_s;
    logic [1:0]    pop_s;
    logic          in_ready_s;
    logic [n-1:0]  head_s   [2];

    // FIFO status flags, derived from occupancy only.
    always_comb begin
        full_s  = 2'b00;
        valid_s = 2'b00;
        for (int i = 0; i < 2; i++) begin
            full_s[i]  = (occ_r[i] == FULL_LVL);
            valid_s[i] = (occ_r[i] != {(AW+1){1'b0}});
        end
    end

    // Input acceptance and push/pop strobes. in_ready looks only at the
    // selected FIFO's fullness, never at the consumer ready inputs, so a
    // full FIFO refuses a word even when it is being popped this cycle.
    always_comb begin
        ready_s = {b_ready, a_ready};
        if (in_sel) begin
            in_ready_s = ~full_s[1];
        end else begin
            in_ready_s = ~full_s[0];
        end
        push_s[0] = in_valid & in_ready_s & ~in_sel;
        push_s[1] = in_valid & in_ready_s &  in_sel;
        pop_s     = valid_s & ready_s;
    end

    // Pointer and occupancy bookkeeping for both FIFOs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                wr_ptr_r[i] <= {AW{1'b0}};
                rd_ptr_r[i] <= {AW{1'b0}};
                occ_r[i]    <= {(AW+1){1'b0}};
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push_s[i]) begin
                    wr_ptr_r[i] <= wr_ptr_r[i] + AW'(1'b1);
                end else begin
                    wr_ptr_r[i] <= wr_ptr_r[i];
                end
                if (pop_s[i]) begin
                    rd_ptr_r[i] <= rd_ptr_r[i] + AW'(1'b1);
                end else begin
                    rd_ptr_r[i] <= rd_ptr_r[i];
                end
                case ({push_s[i], pop_s[i]})
                    2'b10:   occ_r[i] <= occ_r[i] + (AW+1)'(1'b1);
                    2'b01:   occ_r[i] <= occ_r[i] - (AW+1)'(1'b1);
                    default: occ_r[i] <= occ_r[i];
                endcase
            end
        end
    end

    // Word storage; contents are meaningless outside the occupied window,
    // so no reset is needed here.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (push_s[i]) begin
                mem_r[i][wr_ptr_r[i]] <= in_data;
            end
        end
    end

    // Head-of-FIFO words, forced to zero while the FIFO is empty.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            if (valid_s[i]) begin
                head_s[i] = mem_r[i][rd_ptr_r[i]];
            end else begin
                head_s[i] = {n{1'b0}};
            end
        end
    end

    assign in_ready = in_ready_s;
    assign a_valid  = valid_s[0];
    assign b_valid  = valid_s[1];
    assign a_data   = head_s[0];
    assign b_data   = head_s[1];

`ifdef STREAM_DEMUX2_STATS_EN
    logic [15:0] stat_r [2];

    // Per-port pop counters, wrapping naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_r[0] <= 16'h0000;
            stat_r[1] <= 16'h0000;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (pop_s[i]) begin
                    stat_r[i] <= stat_r[i] + 16'd1;
                end else begin
                    stat_r[i] <= stat_r[i];
                end
            end
        end
    end

    assign cnt_a = stat_r[0];
    assign cnt_b = stat_r[1];
`endif

endmodule

// File: tb/tb_stream_demux2.sv
// Self-checking bench for stream_demux2 (n=8, DEPTH=2). The reference model
// is a pair of queues: a word is accepted when the queue it is aimed at
// holds fewer than DEPTH entries, and leaves the queue when its consumer is
// ready. Inputs change on the falling edge; outputs are checked 1 ns later.

module tb_stream_demux2;

    localparam int N = 8;
    localparam int D = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] in_data = 8'h00;
    logic         in_sel = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] a_data;
    logic         a_valid;
    logic         a_ready = 1'b0;
    logic [N-1:0] b_data;
    logic         b_valid;
    logic         b_ready = 1'b0;
`ifdef STREAM_DEMUX2_STATS_EN
    logic [15:0]  cnt_a;
    logic [15:0]  cnt_b;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0]  qa[$];
    logic [7:0]  qb[$];
    logic [7:0]  got_a[$];
    logic [7:0]  got_b[$];
    logic [15:0] ca = 16'd0;
    logic [15:0] cb = 16'd0;

    stream_demux2 #(.n(N), .DEPTH(D)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_data   (a_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .b_data   (b_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready)
`ifdef STREAM_DEMUX2_STATS_EN
        ,
        .cnt_a    (cnt_a),
        .cnt_b    (cnt_b)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic model_ready();
        if (in_sel) return (qb.size() < D);
        else        return (qa.size() < D);
    endfunction

    // {in_ready, a_valid, a_data, b_valid, b_data} as the model predicts.
    function automatic logic [18:0] model_view();
        logic [7:0] ha;
        logic [7:0] hb;
        ha = (qa.size() != 0) ? qa[0] : 8'h00;
        hb = (qb.size() != 0) ? qb[0] : 8'h00;
        return {model_ready(), qa.size() != 0, ha, qb.size() != 0, hb};
    endfunction

    task automatic set_in(input logic v, input logic s, input logic [7:0] d,
                          input logic ar, input logic br);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
        a_ready  = ar;
        b_ready  = br;
        #1;
    endtask

    // Advance one clock, updating the model with what the handshakes imply.
    task automatic tick();
        logic       acc;
        logic       pa;
        logic       pb;
        logic       s;
        logic [7:0] d;
        acc = rst_n && in_valid && model_ready();
        pa  = rst_n && (qa.size() != 0) && a_ready;
        pb  = rst_n && (qb.size() != 0) && b_ready;
        s   = in_sel;
        d   = in_data;
        if (pa) got_a.push_back(a_data);
        if (pb) got_b.push_back(b_data);
        @(posedge clk);
        if (pa) begin void'(qa.pop_front()); ca = ca + 16'd1; end
        if (pb) begin void'(qb.pop_front()); cb = cb + 16'd1; end
        if (acc) begin
            if (s) qb.push_back(d);
            else   qa.push_back(d);
        end
        @(negedge clk);
    endtask

    task automatic model_clear();
        qa.delete(); qb.delete();
        ca = 16'd0; cb = 16'd0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_clear();
        set_in(1'b1, 1'b0, 8'hFF, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({in_ready, a_valid, a_data, b_valid, b_data} !== 19'h40000) begin
                errors++;
                $display("FAIL reset_state act=%h exp=%h",
                         {in_ready, a_valid, a_data, b_valid, b_data}, 19'h40000);
            end
            tick();
        end
        rst_n = 1'b1;
        set_in(1'b1, 1'b0, 8'h5A, 1'b0, 1'b0);
        checks++;
        if ({in_ready, a_valid, a_data, b_valid, b_data} !== model_view()) begin
            errors++;
            $display("FAIL reset_first_push act=%h exp=%h",
                     {in_ready, a_valid, a_data, b_valid, b_data}, model_view());
        end
        tick();
        set_in(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        checks++;
        if ({a_valid, a_data, b_valid} !== {1'b1, 8'h5A, 1'b0}) begin
            errors++;
            $display("FAIL reset_5a_out act=%h exp=%h",
                     {a_valid, a_data, b_valid}, {1'b1, 8'h5A, 1'b0});
        end
        set_in(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        tick();
        tick();
    endtask

    task automatic test_routing();
        logic [7:0] dv [3];
        logic       sv [3];
        dv = '{8'h11, 8'h22, 8'h33};
        sv = '{1'b0, 1'b1, 1'b0};
        got_a.delete(); got_b.delete();
        for (int i = 0; i < 6; i++) begin
            if (i < 3) set_in(1'b1, sv[i], dv[i], 1'b1, 1'b1);
            else       set_in(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
            checks++;
            if ({in_ready, a_valid, a_data, b_valid, b_data} !== model_view()) begin
                errors++;
                $display("FAIL routing_view cyc=%0d act=%h exp=%h", i,
                         {in_ready, a_valid, a_data, b_valid, b_data}, model_view());
            end
            tick();
        end
        checks++;
        if (got_a.size() != 2 || got_b.size() != 1 ||
            got_a[0] !== 8'h11 || got_a[1] !== 8'h33 || got_b[0] !== 8'h22) begin
            errors++;
            $display("FAIL routing_order act_a=%p act_b=%p exp_a=11,33 exp_b=22", got_a, got_b);
        end
    endtask

    task automatic test_full();
        got_a.delete();
        set_in(1'b1, 1'b0, 8'hA0, 1'b0, 1'b0); tick();
        set_in(1'b1, 1'b0, 8'hA1, 1'b0, 1'b0); tick();
        set_in(1'b1, 1'b0, 8'hA2, 1'b0, 1'b0);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL full_blocks act=%b exp=0", in_ready);
        end
        tick();
        set_in(1'b1, 1'b0, 8'hA2, 1'b1, 1'b0);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL full_no_passthru act=%b exp=0", in_ready);
        end
        tick();
        set_in(1'b1, 1'b0, 8'hA2, 1'b0, 1'b0);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL full_released act=%b exp=1", in_ready);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            set_in(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
            checks++;
            if ({in_ready, a_valid, a_data, b_valid, b_data} !== model_view()) begin
                errors++;
                $display("FAIL full_drain_view cyc=%0d act=%h exp=%h", i,
                         {in_ready, a_valid, a_data, b_valid, b_data}, model_view());
            end
            tick();
        end
        checks++;
        if (got_a.size() != 3 || got_a[0] !== 8'hA0 || got_a[1] !== 8'hA1 || got_a[2] !== 8'hA2) begin
            errors++;
            $display("FAIL full_order act=%p exp=A0,A1,A2", got_a);
        end
    endtask

    task automatic test_simul_push_pop();
        set_in(1'b1, 1'b0, 8'h66, 1'b0, 1'b0); tick();
        set_in(1'b1, 1'b0, 8'h77, 1'b1, 1'b0);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL simul_ready act=%b exp=1", in_ready);
        end
        tick();
        set_in(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        checks++;
        // One entry left: valid, head is the new word, and A still not full.
        if ({in_ready, a_valid, a_data} !== {1'b1, 1'b1, 8'h77}) begin
            errors++;
            $display("FAIL simul_state act=%h exp=%h", {in_ready, a_valid, a_data}, {1'b1, 1'b1, 8'h77});
        end
        set_in(1'b0, 1'b0, 8'h00, 1'b1, 1'b1); tick(); tick();
    endtask

    task automatic test_head_of_line();
        set_in(1'b1, 1'b0, 8'hC0, 1'b0, 1'b0); tick();
        set_in(1'b1, 1'b0, 8'hC1, 1'b0, 1'b0); tick();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 1'b0, 8'hC2, 1'b0, 1'b1);
            checks++;
            if ({in_ready, b_valid} !== 2'b00) begin
                errors++;
                $display("FAIL hol_blocked cyc=%0d act=%b exp=00", i, {in_ready, b_valid});
            end
            tick();
        end
        set_in(1'b1, 1'b0, 8'hC2, 1'b1, 1'b0); tick();
        set_in(1'b1, 1'b0, 8'hC2, 1'b0, 1'b0);
        checks++;
        if ({in_ready, b_valid} !== 2'b10) begin
            errors++; $display("FAIL hol_release act=%b exp=10", {in_ready, b_valid});
        end
        tick();
        set_in(1'b1, 1'b1, 8'hD5, 1'b0, 1'b0);
        checks++;
        if ({in_ready, b_valid} !== 2'b10) begin
            errors++; $display("FAIL hol_b_accept act=%b exp=10", {in_ready, b_valid});
        end
        tick();
        set_in(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        checks++;
        if ({a_valid, a_data, b_valid, b_data} !== {1'b1, 8'hC1, 1'b1, 8'hD5}) begin
            errors++;
            $display("FAIL hol_final act=%h exp=%h", {a_valid, a_data, b_valid, b_data},
                     {1'b1, 8'hC1, 1'b1, 8'hD5});
        end
        set_in(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                   8'($urandom_range(0, 255)),
                   $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0);
            checks++;
            if ({in_ready, a_valid, a_data, b_valid, b_data} !== model_view()) begin
                errors++;
                $display("FAIL random_view cyc=%0d act=%h exp=%h", i,
                         {in_ready, a_valid, a_data, b_valid, b_data}, model_view());
            end
`ifdef STREAM_DEMUX2_STATS_EN
            checks++;
            if ({cnt_a, cnt_b} !== {ca, cb}) begin
                errors++;
                $display("FAIL random_cnt cyc=%0d act=%h exp=%h", i, {cnt_a, cnt_b}, {ca, cb});
            end
`endif
            tick();
        end
    endtask

`ifdef STREAM_DEMUX2_STATS_EN
    task automatic test_stats();
        rst_n = 1'b0;
        model_clear();
        set_in(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        set_in(1'b1, 1'b0, 8'h01, 1'b1, 1'b1); tick();
        set_in(1'b1, 1'b1, 8'h02, 1'b1, 1'b1); tick();
        set_in(1'b1, 1'b0, 8'h03, 1'b1, 1'b1); tick();
        set_in(1'b1, 1'b0, 8'h04, 1'b1, 1'b1); tick();
        set_in(1'b0, 1'b0, 8'h00, 1'b1, 1'b1); tick(); tick();
        checks++;
        if ({cnt_a, cnt_b} !== {16'd3, 16'd1}) begin
            errors++;
            $display("FAIL stats_counts act=%h exp=%h", {cnt_a, cnt_b}, {16'd3, 16'd1});
        end
        set_in(1'b1, 1'b0, 8'h05, 1'b0, 1'b0); tick();
        set_in(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b0;
        model_clear();
        #1;
        checks++;
        if ({cnt_a, cnt_b, a_valid, b_valid} !== 34'h0) begin
            errors++;
            $display("FAIL stats_midreset act=%h exp=0", {cnt_a, cnt_b, a_valid, b_valid});
        end
        tick();
        rst_n = 1'b1;
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_routing();
        test_full();
        test_simul_push_pop();
        test_head_of_line();
        test_random();
`ifdef STREAM_DEMUX2_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
